conv3x3_mac_pipe: RTL and testbench

//  Downstream consumer of linebuffer_3x3: takes the 9-pixel window it emits each stream beat and produces one
//  3x3 convolution output pixel (valid-padding) per valid window. Tracks row/col position to discard windows

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv3x3_dot9.sv | 49 ++++
 rtl/conv3x3_mac_pipe.sv | 151 +++++++++++++++
 tb/tb_conv3x3_mac_pipe.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, types and output rounding for the conv stages
package conv_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int ACC_W  = 2 * DATA_W + 4;

  typedef logic signed [DATA_W-1:0] pix_t;
  typedef pix_t win_t [8:0];
  typedef logic signed [ACC_W-1:0] acc_t;

  // Per-window values that ride alongside the dot product until the output stage
  typedef struct packed {
    pix_t bias;
    logic relu;
    logic last;
  } side_t;

  localparam acc_t RND_HALF = acc_t'(2 ** (FRAC_W - 1));
  localparam acc_t SAT_HI   = acc_t'(2 ** (DATA_W - 1) - 1);
  localparam acc_t SAT_LO   = acc_t'(-(2 ** (DATA_W - 1)));

  // Round half up, drop the fractional product bits, clamp to the pixel range
  function automatic pix_t sat_round(input acc_t acc);
    acc_t shifted;
    shifted = (acc + RND_HALF) >>> FRAC_W;
    if (shifted > SAT_HI) return pix_t'(SAT_HI);
    if (shifted < SAT_LO) return pix_t'(SAT_LO);
    return pix_t'(shifted);
  endfunction

endpackage

// File: rtl/conv3x3_dot9.sv
// rtl/conv3x3_dot9.sv - two-stage 9-tap multiply and partial-sum tree
module conv3x3_dot9
  import conv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  win_t win,
  input  win_t wgt,
  output logic out_valid,
  output acc_t psum [3]
);

  typedef logic signed [2*DATA_W-1:0] prod_t;

  prod_t prod [9];
  logic  prod_valid;

  // Multiply stage: nine full-width signed products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_valid <= 1'b0;
      prod       <= '{default: '0};
    end else begin
      prod_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < 9; i++) begin
          prod[i] <= prod_t'(win[i]) * prod_t'(wgt[i]);
        end
      end
    end
  end

  // Adder stage: one sign-extended partial sum per window row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      psum      <= '{default: '0};
    end else begin
      out_valid <= prod_valid;
      if (prod_valid) begin
        for (int j = 0; j < 3; j++) begin
          psum[j] <= acc_t'(prod[3*j]) + acc_t'(prod[3*j+1]) + acc_t'(prod[3*j+2]);
        end
      end
    end
  end

endmodule

// File: rtl/conv3x3_mac_pipe.sv
// rtl/conv3x3_mac_pipe.sv - 3x3 valid-padding convolution over linebuffer windows
module conv3x3_mac_pipe
  import conv_pkg::*;
#(
  parameter int IMG_W = 16,
  parameter int IMG_H = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  win_t ifmap_3x3,
  input  logic wgt_valid,
  input  pix_t wgt_data,
  input  pix_t bias,
  input  logic relu_en,
  output logic wgt_ready,
  output logic out_valid,
  output pix_t ofmap_data,
  output logic frame_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [3:0]       wgt_idx;
  win_t             shadow;
  win_t             active;

  logic frame_start, win_valid, win_last, commit;

  assign frame_start = in_valid && (row == '0) && (col == '0);
  assign win_valid   = in_valid && (row >= ROW_W'(2)) && (col >= COL_W'(2));
  assign win_last    = win_valid && (row == ROW_W'(IMG_H - 1)) && (col == COL_W'(IMG_W - 1));
  assign commit      = frame_start && wgt_ready;

  // Raster position of the incoming pixel; advances only on accepted pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (col == COL_W'(IMG_W - 1)) begin
        col <= '0;
        row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Shadow fill and frame-boundary commit; a beat after a full bank restarts the fill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '{default: '0};
      active    <= '{default: '0};
      wgt_idx   <= '0;
      wgt_ready <= 1'b0;
    end else begin
      if (wgt_valid) begin
        if (wgt_ready) begin
          shadow[0] <= wgt_data;
          wgt_idx   <= 4'd1;
          wgt_ready <= 1'b0;
        end else begin
          shadow[wgt_idx] <= wgt_data;
          if (wgt_idx == 4'd8) begin
            wgt_idx   <= '0;
            wgt_ready <= 1'b1;
          end else begin
            wgt_idx <= wgt_idx + 4'd1;
          end
        end
      end
      if (commit) begin
        active    <= shadow;
        wgt_ready <= 1'b0;
      end
    end
  end

  win_t  s1_win, s1_wgt;
  logic  s1_valid;
  side_t s1_side, s2_side, s3_side;

  // Capture stage; the frame-start pixel already sees the bank being committed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_win   <= '{default: '0};
      s1_wgt   <= '{default: '0};
      s1_side  <= '0;
    end else begin
      s1_valid <= win_valid;
      if (win_valid) begin
        s1_win  <= ifmap_3x3;
        s1_wgt  <= commit ? shadow : active;
        s1_side <= '{bias: bias, relu: relu_en, last: win_last};
      end
    end
  end

  logic dot_valid;
  acc_t psum [3];

  conv3x3_dot9 u_dot9 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .win       (s1_win),
    .wgt       (s1_wgt),
    .out_valid (dot_valid),
    .psum      (psum)
  );

  // Sideband delay matching the two dot-product stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_side <= '0;
      s3_side <= '0;
    end else begin
      s2_side <= s1_side;
      s3_side <= s2_side;
    end
  end

  acc_t acc_sum;
  pix_t result;

  // Final sum with bias aligned to the product's binary point, then round/saturate/ReLU
  always_comb begin
    acc_sum = psum[0] + psum[1] + psum[2] + (acc_t'(signed'(s3_side.bias)) <<< FRAC_W);
    result  = sat_round(acc_sum);
    if (s3_side.relu && result[DATA_W-1]) result = '0;
  end

  // Output register; data holds its last value between results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      ofmap_data <= '0;
    end else begin
      out_valid  <= dot_valid;
      frame_done <= dot_valid && s3_side.last;
      if (dot_valid) ofmap_data <= result;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac_pipe.sv
// tb/tb_conv3x3_mac_pipe.sv - scoreboard bench for conv3x3_mac_pipe
module tb_conv3x3_mac_pipe;
  import conv_pkg::*;

  typedef struct {
    int   due;
    pix_t data;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, in_valid, in_valid16, wgt_valid, relu_en;
  win_t ifmap;
  pix_t wgt_data, bias;
  logic wgt_ready, out_valid, frame_done;
  pix_t ofmap_data;
  logic wgt_ready16, out_valid16, frame_done16;
  pix_t ofmap_data16;

  conv3x3_mac_pipe #(.IMG_W(4), .IMG_H(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .ifmap_3x3(ifmap),
    .wgt_valid(wgt_valid), .wgt_data(wgt_data), .bias(bias), .relu_en(relu_en),
    .wgt_ready(wgt_ready), .out_valid(out_valid), .ofmap_data(ofmap_data),
    .frame_done(frame_done)
  );

  conv3x3_mac_pipe #(.IMG_W(16), .IMG_H(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .ifmap_3x3(ifmap),
    .wgt_valid(wgt_valid), .wgt_data(wgt_data), .bias(bias), .relu_en(relu_en),
    .wgt_ready(wgt_ready16), .out_valid(out_valid16), .ofmap_data(ofmap_data16),
    .frame_done(frame_done16)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_out16  = 0;
  int   n_fd16   = 0;
  logic cap      = 1'b0;

  win_t m_shadow, m_active, zw;
  int   m_idx, m_row, m_col, m_row16, m_col16;
  logic m_ready;
  exp_t q[$];
  exp_t q16[$];
  pix_t wq[$];
  pix_t got_q[$];
  exp_t mon_e, mon_e16;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic pix_t model(input win_t w, input win_t k, input pix_t b, input logic relu);
    longint s;
    s = 0;
    for (int i = 0; i < 9; i++) s += longint'(w[i]) * longint'(k[i]);
    s = s + longint'(b) * 256 + 128;
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return pix_t'(s);
  endfunction

  function automatic pix_t wset(input int kind, input int i);
    case (kind)
      1:       return 16'sh0100;
      2:       return pix_t'(i * 64 - 256);
      3:       return pix_t'(32 * (i + 1));
      4:       return pix_t'(80 - 48 * (i % 3));
      5:       return 16'sh7FFF;
      6:       return 16'sh8000;
      7:       return (i == 4) ? 16'sh0080 : 16'sh0000;
      default: return (i == 4) ? 16'sh007F : 16'sh0000;
    endcase
  endfunction

  function automatic win_t win_at(input int mode, input int r, input int c);
    win_t w;
    w = '{default: '0};
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        case (mode)
          0: if (r >= 2 && c >= 2) w[3*i+j] = pix_t'(((r - 2 + i) * 4 + (c - 2 + j) + 1) * 256);
          1: w[3*i+j] = 16'sh7FFF;
          default: w[3*i+j] = (i == 1 && j == 1) ? 16'sh0001 : 16'sh0000;
        endcase
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_shadow = '{default: '0};
    m_active = '{default: '0};
    m_idx = 0; m_ready = 1'b0;
    m_row = 0; m_col = 0; m_row16 = 0; m_col16 = 0;
    q.delete(); q16.delete();
  endtask

  task automatic drive(input logic iv, input win_t w, input logic wv, input pix_t wd, input logic iv16);
    logic commit, rdy_old;
    win_t use_w;
    exp_t e;
    in_valid = iv; ifmap = w; wgt_valid = wv; wgt_data = wd; in_valid16 = iv16;
    rdy_old = m_ready;
    commit  = iv && m_row == 0 && m_col == 0 && m_ready;
    use_w   = m_active;
    if (commit) use_w = m_shadow;
    if (iv && m_row >= 2 && m_col >= 2) begin
      e.due = cyc + 4; e.data = model(w, use_w, bias, relu_en); e.last = (m_row == 3 && m_col == 3);
      q.push_back(e);
    end
    if (commit) begin m_active = m_shadow; m_ready = 1'b0; end
    if (wv) begin
      if (rdy_old) begin
        m_shadow[0] = wd; m_idx = 1; m_ready = 1'b0;
      end else begin
        m_shadow[m_idx] = wd;
        if (m_idx == 8) begin m_idx = 0; m_ready = 1'b1; end
        else m_idx++;
      end
    end
    if (iv) begin
      if (m_col == 3) begin m_col = 0; m_row = (m_row == 3) ? 0 : m_row + 1; end
      else m_col++;
    end
    if (iv16) begin
      if (m_row16 >= 2 && m_col16 >= 2) begin
        e.due = cyc + 4; e.data = '0; e.last = (m_row16 == 15 && m_col16 == 15);
        q16.push_back(e);
      end
      if (m_col16 == 15) begin m_col16 = 0; m_row16 = (m_row16 == 15) ? 0 : m_row16 + 1; end
      else m_col16++;
    end
    @(posedge clk); #1;
    check("wgt_ready", wgt_ready, m_ready);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, zw, 1'b0, '0, 1'b0);
  endtask

  task automatic push_set(input int kind);
    for (int i = 0; i < 9; i++) wq.push_back(wset(kind, i));
  endtask

  task automatic load_all();
    pix_t wd;
    while (wq.size() > 0) begin
      wd = wq.pop_front();
      drive(1'b0, zw, 1'b1, wd, 1'b0);
    end
  endtask

  task automatic stream_frame(input int mode, input int wstart, input bit gaps);
    pix_t wd;
    logic wv;
    for (int p = 0; p < 16; p++) begin
      wv = 1'b0; wd = '0;
      if (p >= wstart && wq.size() > 0) begin wv = 1'b1; wd = wq.pop_front(); end
      drive(1'b1, win_at(mode, p / 4, p % 4), wv, wd, 1'b0);
      if (gaps && (p % 5 == 3)) drive(1'b0, win_at(1, 0, 0), 1'b0, '0, 1'b0);
    end
  endtask

  task automatic capture_frame(input int mode, input string tag, input pix_t exp);
    got_q.delete();
    cap = 1'b1;
    stream_frame(mode, 16, 1'b1);
    idle(6);
    cap = 1'b0;
    check({tag, "_count"}, got_q.size(), 4);
    foreach (got_q[k]) check(tag, got_q[k], exp);
  endtask

  // Scoreboard pop on every produced result
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        else begin
          mon_e = q.pop_front();
          check("out_cycle", cyc, mon_e.due);
          check("ofmap_data", ofmap_data, mon_e.data);
          check("frame_done", frame_done, mon_e.last);
          if (cap) got_q.push_back(ofmap_data);
        end
      end else if (frame_done) check("frame_done_idle", frame_done, 1'b0);
      if (out_valid16) begin
        n_out16++;
        if (frame_done16) n_fd16++;
        if (q16.size() == 0) check("spurious_out_valid16", out_valid16, 1'b0);
        else begin
          mon_e16 = q16.pop_front();
          check("out_cycle16", cyc, mon_e16.due);
          check("frame_done16", frame_done16, mon_e16.last);
        end
      end
    end
  end

  initial begin
    pix_t t1_exp [4];
    t1_exp = '{16'sh3600, 16'sh3F00, 16'sh5A00, 16'sh6300};
    zw = '{default: '0};
    rst_n = 1'b0; in_valid = 1'b0; in_valid16 = 1'b0; wgt_valid = 1'b0;
    wgt_data = '0; bias = '0; relu_en = 1'b0; ifmap = zw;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_ofmap", ofmap_data, 16'h0000);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_wgt_ready", wgt_ready, 1'b0);
    rst_n = 1'b1;

    // Unit weights over a ramp image
    push_set(1);
    load_all();
    got_q.delete();
    cap = 1'b1;
    stream_frame(0, 16, 1'b0);
    idle(6);
    cap = 1'b0;
    check("t1_count", got_q.size(), 4);
    foreach (got_q[k]) if (k < 4) check("t1_value", got_q[k], t1_exp[k]);

    // Edge discard on a full 16x16 frame
    for (int i = 0; i < 256; i++) drive(1'b0, zw, 1'b0, '0, 1'b1);
    idle(6);
    check("t2_out_count", n_out16, 196);
    check("t2_frame_done_count", n_fd16, 1);

    // Saturation and ReLU
    push_set(5); load_all();
    capture_frame(1, "t3_sat_pos", 16'sh7FFF);
    push_set(6); load_all();
    capture_frame(1, "t3_sat_neg", 16'sh8000);
    relu_en = 1'b1;
    capture_frame(1, "t3_relu", 16'sh0000);
    relu_en = 1'b0;

    // Rounding at half an LSB
    push_set(7); load_all();
    capture_frame(2, "t4_round_up", 16'sh0001);
    push_set(8); load_all();
    capture_frame(2, "t4_round_down", 16'sh0000);

    // Weight swap timing, restart and same-cycle completion
    bias = 16'sh0080;
    push_set(1); load_all();
    push_set(2);
    stream_frame(0, 3, 1'b1);
    relu_en = 1'b1;
    stream_frame(0, 16, 1'b0);
    relu_en = 1'b0;
    push_set(3); push_set(4); load_all();
    stream_frame(0, 16, 1'b1);
    push_set(1);
    for (int i = 0; i < 8; i++) begin
      pix_t wd;
      wd = wq.pop_front();
      drive(1'b0, zw, 1'b1, wd, 1'b0);
    end
    stream_frame(0, 0, 1'b0);
    stream_frame(0, 16, 1'b0);
    bias = '0;
    idle(6);

    // Asynchronous reset mid-frame
    push_set(3); load_all();
    for (int p = 0; p < 14; p++) drive(1'b1, win_at(0, p / 4, p % 4), 1'b0, '0, 1'b0);
    check("t6_pre_reset_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_async_out_valid", out_valid, 1'b0);
    check("t6_async_frame_done", frame_done, 1'b0);
    check("t6_async_ofmap", ofmap_data, 16'h0000);
    model_reset();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push_set(2); load_all();
    stream_frame(0, 16, 1'b1);
    idle(8);

    check("sb_empty", q.size(), 0);
    check("sb16_empty", q16.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
